acc_divider: RTL and testbench

- Sequential unsigned restoring divider for the 6-bit accumulator datapath; the subtract-based inverse of the ripple-carry adder ALU.
- Divides the accumulator value (dividend) by an operand (divisor) and produces quotient and remainder.
- Computes one quotient bit per clock, with a start/busy/done handshake to the accumulator controller.

---
 rtl/acc_pkg.sv | 14 +
 rtl/acc_sub_stage.sv | 14 +
 rtl/acc_divider.sv | 161 ++++++++++++++++
 tb/tb_acc_divider.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types and constants for the 6-bit accumulator datapath.
// The divider's FSM state type and operand width live here.
package acc_pkg;

  localparam int ACC_WIDTH = 6;
  localparam int ACC_CNT_W = $clog2(ACC_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

endpackage

// File: rtl/acc_sub_stage.sv
// Combinational W-bit subtractor (a - b) used for the divider's per-cycle trial subtract.
// borrow_o is set when a_i < b_i (unsigned).
module acc_sub_stage #(
  parameter int W = 7
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};

endmodule

// File: rtl/acc_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define ACC_DIV_SIGNED_EN for two's-complement operands (truncating division).
//
// Handshake: start is sampled only in IDLE; busy is high in RUN and DONE;
// done is a one-cycle pulse in DONE, and quotient/remainder/div_by_zero
// stay valid until the next accepted start.
module acc_divider
  import acc_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ZERO = '0;

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] quot_fix, rem_fix;
  logic [WIDTH:0]   trial_a, trial_b, trial_diff;
  logic             trial_borrow;
  logic             unused_trial_msb;

  acc_sub_stage #(.W(WIDTH + 1)) u_sub (
    .a_i      (trial_a),
    .b_i      (trial_b),
    .diff_o   (trial_diff),
    .borrow_o (trial_borrow)
  );

  assign trial_a = {part_q, shift_q[WIDTH-1]};
  assign trial_b = {1'b0, dvsr_q};
  // A successful trial always leaves the top bit clear, so only the low bits are kept.
  assign unused_trial_msb = trial_diff[WIDTH];

`ifdef ACC_DIV_SIGNED_EN
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;

  // The most-negative value maps to itself, which reads correctly as an unsigned magnitude.
  assign dvd_mag  = dividend[WIDTH-1] ? (ZERO - dividend) : dividend;
  assign dvs_mag  = divisor[WIDTH-1]  ? (ZERO - divisor)  : divisor;
  assign quot_fix = neg_quot_q ? (ZERO - shift_d) : shift_d;
  assign rem_fix  = neg_rem_q  ? (ZERO - part_d)  : part_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  always_comb begin
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    if (state_q == IDLE && start) begin
      neg_quot_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_rem_d  = dividend[WIDTH-1];
    end
  end
`else
  assign dvd_mag  = dividend;
  assign dvs_mag  = divisor;
  assign quot_fix = shift_d;
  assign rem_fix  = part_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      part_q  <= '0;
      dvsr_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      part_q  <= part_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    part_d  = part_q;
    dvsr_d  = dvsr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == ZERO) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            dvsr_d  = dvs_mag;
            shift_d = dvd_mag;
            part_d  = '0;
            cnt_d   = CNT_W'(WIDTH - 1);
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // Dividend bits shift out at the MSB while quotient bits fill in at the LSB.
        part_d  = trial_borrow ? trial_a[WIDTH-1:0] : trial_diff[WIDTH-1:0];
        shift_d = {shift_q[WIDTH-2:0], ~trial_borrow};
        if (cnt_q == '0) begin
          quot_d  = quot_fix;
          rem_d   = rem_fix;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_acc_divider.sv
// Directed, table-driven bench for acc_divider plus hand-written multi-cycle sequences.
// Expected results follow the ACC_DIV_SIGNED_EN setting of the build.
module tb_acc_divider;

  localparam int W = 6;
  localparam int MAX_WAIT = 20;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int passed;
  int total;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_dbz;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs[NVEC];

`ifdef ACC_DIV_SIGNED_EN
  localparam logic [W-1:0] Q_45_7 = 6'd62;  // -19 / 7 = -2
  localparam logic [W-1:0] R_45_7 = 6'd59;  // remainder -5
`else
  localparam logic [W-1:0] Q_45_7 = 6'd6;
  localparam logic [W-1:0] R_45_7 = 6'd3;
`endif

  acc_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Counts negedges from just after the accepting posedge until done is seen.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < MAX_WAIT);
  endtask

  task automatic launch(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    @(negedge clk);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int lat, input int exp_lat,
                              input logic [W-1:0] eq, input logic [W-1:0] er,
                              input logic edbz);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, div_by_zero, edbz);
  endtask

  initial begin
    int lat;
    int lat2;
    int seen_done;
    passed   = 0;
    total    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

`ifdef ACC_DIV_SIGNED_EN
    vecs[0]  = '{6'd45, 6'd7,  6'd62, 6'd59, 1'b0};
    vecs[1]  = '{6'd44, 6'd3,  6'd58, 6'd62, 1'b0};
    vecs[2]  = '{6'd32, 6'd63, 6'd32, 6'd0,  1'b0};
    vecs[3]  = '{6'd20, 6'd0,  6'd63, 6'd20, 1'b1};
    vecs[4]  = '{6'd12, 6'd4,  6'd3,  6'd0,  1'b0};
    vecs[5]  = '{6'd8,  6'd3,  6'd2,  6'd2,  1'b0};
    vecs[6]  = '{6'd63, 6'd1,  6'd63, 6'd0,  1'b0};
    vecs[7]  = '{6'd5,  6'd9,  6'd0,  6'd5,  1'b0};
    vecs[8]  = '{6'd31, 6'd63, 6'd33, 6'd0,  1'b0};
    vecs[9]  = '{6'd0,  6'd5,  6'd0,  6'd0,  1'b0};
    vecs[10] = '{6'd0,  6'd0,  6'd63, 6'd0,  1'b1};
`else
    vecs[0]  = '{6'd45, 6'd7,  6'd6,  6'd3,  1'b0};
    vecs[1]  = '{6'd63, 6'd1,  6'd63, 6'd0,  1'b0};
    vecs[2]  = '{6'd5,  6'd9,  6'd0,  6'd5,  1'b0};
    vecs[3]  = '{6'd20, 6'd0,  6'd63, 6'd20, 1'b1};
    vecs[4]  = '{6'd12, 6'd4,  6'd3,  6'd0,  1'b0};
    vecs[5]  = '{6'd8,  6'd3,  6'd2,  6'd2,  1'b0};
    vecs[6]  = '{6'd63, 6'd63, 6'd1,  6'd0,  1'b0};
    vecs[7]  = '{6'd0,  6'd5,  6'd0,  6'd0,  1'b0};
    vecs[8]  = '{6'd62, 6'd8,  6'd7,  6'd6,  1'b0};
    vecs[9]  = '{6'd1,  6'd63, 6'd0,  6'd1,  1'b0};
    vecs[10] = '{6'd0,  6'd0,  6'd63, 6'd0,  1'b1};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset div_by_zero", div_by_zero, 0);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      launch(vecs[i].dvd, vecs[i].dvs);
      check($sformatf("vec%0d busy", i), busy, 1);
      wait_done(lat);
      check_result($sformatf("vec%0d", i), lat, vecs[i].exp_dbz ? 1 : 7,
                   vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_dbz);
      @(negedge clk);
      check($sformatf("vec%0d done pulse width", i), done, 0);
      check($sformatf("vec%0d idle after done", i), busy, 0);
      check($sformatf("vec%0d quotient held", i), quotient, vecs[i].exp_q);
    end

    // Back-to-back with start held high: second start accepted in the cycle after done
    @(negedge clk);
    start    = 1'b1;
    dividend = 6'd63;
    divisor  = 6'd1;
    @(posedge clk);
    wait_done(lat);
    check("b2b first latency", lat, 7);
    check("b2b first quotient", quotient, 63);
    check("b2b first remainder", remainder, 0);
    dividend = 6'd5;
    divisor  = 6'd9;
    @(negedge clk);
    check("b2b idle gap busy", busy, 0);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat2);
    check("b2b second latency", lat2, 7);
    check("b2b second quotient", quotient, 0);
    check("b2b second remainder", remainder, 5);
    @(negedge clk);

    // start while busy is ignored
    launch(6'd45, 6'd7);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 6'd10;
    divisor  = 6'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("ignore start latency", lat + 4, 7);
    check("ignore start quotient", quotient, Q_45_7);
    check("ignore start remainder", remainder, R_45_7);
    @(negedge clk);
    check("ignore start no relaunch", busy, 0);

    // Reset mid-operation aborts immediately with no done pulse
    launch(6'd45, 6'd7);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort quotient", quotient, 0);
    check("abort remainder", remainder, 0);
    check("abort div_by_zero", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1;
    end
    check("abort no done", seen_done, 0);
    launch(6'd8, 6'd3);
    wait_done(lat);
    check_result("after abort 8/3", lat, 7, 6'd2, 6'd2, 1'b0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Safety net so a stuck design still produces a summary.
  initial begin
    #100000;
    total++;
    $display("FAIL timeout: got running expected finished");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
